// File: rtl/game_defs.sv
// Shared game constants: coordinate width, screen size, parked position and the
// one-hot state encoding used by the projectile controller and the enemy fleet.
package game_defs;
  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t PARK_H = '0;
  localparam coord_t PARK_V = '0;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_INIT_OH     = 4'b0001;
  localparam logic [ST_W-1:0] ST_READY_OH    = 4'b0010;
  localparam logic [ST_W-1:0] ST_FLIGHT_OH   = 4'b0100;
  localparam logic [ST_W-1:0] ST_COOLDOWN_OH = 4'b1000;

  typedef enum logic [ST_W-1:0] {
    S_INIT     = ST_INIT_OH,
    S_READY    = ST_READY_OH,
    S_FLIGHT   = ST_FLIGHT_OH,
    S_COOLDOWN = ST_COOLDOWN_OH
  } pp_state_e;
endpackage

// File: rtl/player_projectile_if.sv
// Player-projectile bundle: game control, ship/fire inputs, fleet collision in,
// projectile position/status out. slave = projectile block, master = its driver.
interface player_projectile_if;
  import game_defs::*;

  logic       start;
  logic       stop;
  logic       fire;
  coord_t     ship_h;
  coord_t     ship_v;
  logic       collision;
  coord_t     projectile_h;
  coord_t     projectile_v;
  logic       active;
  logic       shot_fired;
  logic [7:0] shots;

  modport master (
    output start, stop, fire, ship_h, ship_v, collision,
    input  projectile_h, projectile_v, active, shot_fired, shots
  );

  modport slave (
    input  start, stop, fire, ship_h, ship_v, collision,
    output projectile_h, projectile_v, active, shot_fired, shots
  );
endinterface

// File: rtl/move_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick_o is high for the cycle at TICK_DIV-1.
module move_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/player_projectile.sv
// Single in-flight player projectile: launch on fire edge, climb per tick, retire on
// hit or top. Optional post-retirement cooldown via `PROJECTILE_COOLDOWN_EN.
module player_projectile
  import game_defs::*;
#(
  parameter int TICK_DIV       = 250000,
  parameter int STEP           = 5,
  parameter int TOP_LIMIT      = 10,
  parameter int SPAWN_OFFSET   = 20,
  parameter int COOLDOWN_TICKS = 40
) (
  input logic                clk,
  input logic                reset,
  player_projectile_if.slave pif
);
  localparam coord_t SPAWN_MIN  = coord_t'(SPAWN_OFFSET + TOP_LIMIT);
  localparam coord_t SPAWN_OFS  = coord_t'(SPAWN_OFFSET);
  localparam coord_t RETIRE_LIM = coord_t'(TOP_LIMIT + STEP);
  localparam coord_t STEP_C     = coord_t'(STEP);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (COOLDOWN_TICKS < 1 || COOLDOWN_TICKS > 255) begin : g_bad_cd
    $error("COOLDOWN_TICKS must be in 1..255");
  end

`ifdef PROJECTILE_COOLDOWN_EN
  localparam pp_state_e RETIRE_ST = S_COOLDOWN;
  localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_TICKS - 1);
  logic [7:0] cd_q, cd_d;
`else
  localparam pp_state_e RETIRE_ST = S_READY;
`endif

  pp_state_e  state_q, state_d;
  coord_t     pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  logic       active_q, active_d;
  logic       shot_q, shot_d;
  logic [7:0] shots_q, shots_d;
  logic       fire_prev_q;
  logic       tick, fire_edge;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign fire_edge = pif.fire & ~fire_prev_q;

  always_comb begin
    state_d  = state_q;
    pos_h_d  = pos_h_q;
    pos_v_d  = pos_v_q;
    active_d = active_q;
    shot_d   = 1'b0;
    shots_d  = shots_q;
`ifdef PROJECTILE_COOLDOWN_EN
    cd_d     = '0;
`endif
    if (pif.stop) begin
      state_d  = S_INIT;
      pos_h_d  = PARK_H;
      pos_v_d  = PARK_V;
      active_d = 1'b0;
    end else begin
      case (state_q)
        S_INIT: if (pif.start) state_d = S_READY;
        S_READY: begin
          // Too close to the top to spawn a legal position: the edge is swallowed.
          if (fire_edge && pif.ship_v >= SPAWN_MIN) begin
            state_d  = S_FLIGHT;
            pos_h_d  = pif.ship_h;
            pos_v_d  = pif.ship_v - SPAWN_OFS;
            active_d = 1'b1;
            shot_d   = 1'b1;
            if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
          end
        end
        S_FLIGHT: begin
          // Collision beats a coincident tick; top check avoids underflow.
          if (pif.collision || (tick && pos_v_q < RETIRE_LIM)) begin
            state_d  = RETIRE_ST;
            pos_h_d  = PARK_H;
            pos_v_d  = PARK_V;
            active_d = 1'b0;
          end else if (tick) begin
            pos_v_d = pos_v_q - STEP_C;
          end
        end
`ifdef PROJECTILE_COOLDOWN_EN
        S_COOLDOWN: begin
          cd_d = cd_q;
          if (tick) begin
            if (cd_q == CD_LAST) begin
              state_d = S_READY;
              cd_d    = '0;
            end else begin
              cd_d = cd_q + 8'd1;
            end
          end
        end
`endif
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      pos_h_q     <= PARK_H;
      pos_v_q     <= PARK_V;
      active_q    <= 1'b0;
      shot_q      <= 1'b0;
      shots_q     <= '0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_h_q     <= pos_h_d;
      pos_v_q     <= pos_v_d;
      active_q    <= active_d;
      shot_q      <= shot_d;
      shots_q     <= shots_d;
      fire_prev_q <= pif.fire;
    end
  end

`ifdef PROJECTILE_COOLDOWN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cd_q <= '0;
    else       cd_q <= cd_d;
  end
`endif

  assign pif.projectile_h = pos_h_q;
  assign pif.projectile_v = pos_v_q;
  assign pif.active       = active_q;
  assign pif.shot_fired   = shot_q;
  assign pif.shots        = shots_q;
endmodule

// File: tb/tb_player_projectile.sv
// Scoreboard bench: stimulus queues every expected output change; the monitor pops
// one entry per observed change of the output snapshot and compares.
module tb_player_projectile;
  import game_defs::*;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       act;
    logic       sf;
    logic [7:0] shots;
  } snap_t;

  typedef struct {
    snap_t s;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   tcnt;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  player_projectile_if pif();

  player_projectile #(
    .TICK_DIV(4), .STEP(5), .TOP_LIMIT(10), .SPAWN_OFFSET(20), .COOLDOWN_TICKS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif.slave)
  );

  always #5 clk = ~clk;

  // Bench-side copy of the free-running tick phase (period 4 from reset).
  always @(posedge clk or posedge reset) begin
    if (reset) tcnt <= 0;
    else       tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
  end

  initial begin : monitor
    snap_t cur, prev;
    exp_t  e;
    bit    first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {pif.projectile_h, pif.projectile_v, pif.active, pif.shot_fired, pif.shots};
        if (first || cur != prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got h=%0d v=%0d act=%0d sf=%0d shots=%0d, want no change",
                     cur.h, cur.v, cur.act, cur.sf, cur.shots);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e.s) begin
              errors++;
              $display("FAIL %s: got h=%0d v=%0d act=%0d sf=%0d shots=%0d, want h=%0d v=%0d act=%0d sf=%0d shots=%0d",
                       e.name, cur.h, cur.v, cur.act, cur.sf, cur.shots,
                       e.s.h, e.s.v, e.s.act, e.s.sf, e.s.shots);
            end
          end
        end
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  task automatic push(input int h, input int v, input int act, input int sf, input int sh,
                      input string name);
    exp_t e;
    e.s    = {10'(h), 10'(v), 1'(act), 1'(sf), 8'(sh)};
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_launch(input int h, input int v, input int sh, input string name);
    push(h, v, 1, 1, sh, name);
    push(h, v, 1, 0, sh, {name, "_sf_drop"});
  endtask

  task automatic wait_drain(input int n, input string tag);
    for (int i = 0; i < n && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d events outstanding, want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Returns at the negedge just after the next tick edge.
  task automatic tick_wait();
    do @(negedge clk); while (tcnt != 3);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    pif.start = 0; pif.stop = 0; pif.fire = 0; pif.collision = 0;
    pif.ship_h = 0; pif.ship_v = 0;

    push(0, 0, 0, 0, 0, "reset_state");
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_drain(2, "reset");

    pif.start = 1; @(negedge clk); pif.start = 0;

    // Launch from (300,450) and fly to the top with fire held throughout.
    pif.ship_h = 300; pif.ship_v = 450;
    pif.fire = 1;
    push_launch(300, 430, 1, "launch1");
    for (int n = 1; n <= 84; n++) push(300, 430 - 5 * n, 1, 0, 1, "flight1_step");
    push(0, 0, 0, 0, 1, "top_retire1");
    wait_drain(400, "flight1");
    repeat (40) @(negedge clk);
    pif.fire = 0;
    @(negedge clk);

    // Second shot, collision on the tick that would step 400 -> 395.
    pif.fire = 1;
    push_launch(300, 430, 2, "launch2");
    for (int n = 1; n <= 6; n++) push(300, 430 - 5 * n, 1, 0, 2, "flight2_step");
    wait_drain(40, "flight2");
    pif.fire = 0;
    do @(negedge clk); while (tcnt != 3);
    pif.collision = 1;
    push(0, 0, 0, 0, 2, "collision_retire");
    @(negedge clk);
    pif.collision = 0;
`ifdef PROJECTILE_COOLDOWN_EN
    wait_drain(2, "collision");
    tick_wait();
    pif.fire = 1; @(negedge clk); pif.fire = 0;
    tick_wait();
    pif.fire = 1;
    push_launch(300, 430, 3, "launch3_after_cooldown");
`else
    pif.fire = 1;
    push_launch(300, 430, 3, "launch3_next_cycle");
`endif
    wait_drain(6, "launch3");
    push(300, 425, 1, 0, 3, "flight3_step");
    wait_drain(10, "flight3");

    // Stop mid-flight: park, INIT, fire ignored until start.
    pif.fire = 0;
    pif.stop = 1;
    push(0, 0, 0, 0, 3, "stop_park");
    @(negedge clk);
    pif.stop = 0;
    wait_drain(3, "stop");
    pif.fire = 1; repeat (3) @(negedge clk); pif.fire = 0;
    repeat (10) @(negedge clk);
    pif.start = 1; @(negedge clk); pif.start = 0;
    pif.fire = 1;
    push_launch(300, 430, 4, "launch4_after_start");
    wait_drain(6, "launch4");
    pif.fire = 0;
    pif.stop = 1;
    push(0, 0, 0, 0, 4, "stop_park2");
    @(negedge clk);
    pif.stop = 0;
    wait_drain(3, "stop2");
    pif.start = 1; @(negedge clk); pif.start = 0;

    // Spawn threshold: ship_v 25 and 29 refused, 30 accepted at v=10 then retired.
    pif.ship_h = 100; pif.ship_v = 25;
    pif.fire = 1; repeat (2) @(negedge clk); pif.fire = 0;
    repeat (6) @(negedge clk);
    pif.ship_v = 29;
    pif.fire = 1; repeat (2) @(negedge clk); pif.fire = 0;
    repeat (6) @(negedge clk);
    pif.ship_v = 30;
    pif.fire = 1;
    push_launch(100, 10, 5, "launch5_boundary");
    push(0, 0, 0, 0, 5, "top_retire5");
    wait_drain(12, "launch5");
    pif.fire = 0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/player_projectile.md
# player_projectile

Player-side projectile controller for the invader game: turns the fire button and ship position into a single in-flight projectile whose `projectile_h`/`projectile_v` drive the enemy fleet's hit detection. It consumes the fleet's `collision` pulse and win/lose status, retires the projectile on hit or at the top of the playfield, and enforces one-shot-at-a-time plus an optional cooldown. It sits between the player ship/input logic and the enemy fleet, on the 640x480 VGA coordinate grid with 10-bit coordinates.

## Interface
- `TICK_DIV`, 250000: clk cycles per movement tick (>= 2)
- `STEP`, 5: pixels moved upward per tick
- `TOP_LIMIT`, 10: smallest legal in-flight `projectile_v`
- `SPAWN_OFFSET`, 20: launch point distance above `ship_v`
- `COOLDOWN_TICKS`, 40: ticks after retirement before the next shot (1..255)

- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  leave INIT (same start as the fleet)
- `stop`  in  1  game over (fleet `win | lose`); forces INIT
- `fire`  in  1  fire button, already debounced, level
- `ship_h`  in  10  ship horizontal position
- `ship_v`  in  10  ship vertical position
- `collision`  in  1  fleet hit pulse; retires the projectile
- `projectile_h`  out  10  projectile x; 0 when parked
- `projectile_v`  out  10  projectile y; 0 when parked
- `active`  out  1  projectile in flight
- `shot_fired`  out  1  one-cycle pulse on launch
- `shots`  out  8  saturating count of launches since reset

## Operation
- Reset values: `projectile_h`=0, `projectile_v`=0 (parked), `active`=0, `shot_fired`=0, `shots`=0, state INIT, `fire_d`=0, tick counter 0.
- Parked position (0,0) is outside the fleet's reachable area and never registers a hit.
- States: INIT, READY, FLIGHT, COOLDOWN.
- INIT: parked. Goes to READY when `start`=1.
- READY: parked. A fire edge is `fire & ~fire_d`. On a fire edge:
  - If `ship_v >= SPAWN_OFFSET + TOP_LIMIT`: load (`ship_h`, `ship_v - SPAWN_OFFSET`), set `active`=1, pulse `shot_fired`, increment `shots` (holds at 255), and go to FLIGHT.
  - Otherwise the edge is ignored.
- FLIGHT, in priority order:
  - `collision`=1: park, set `active`=0, go to COOLDOWN.
  - Else on a tick, if `projectile_v < TOP_LIMIT + STEP`: park, go to COOLDOWN. There is no subtraction in this case, so no underflow.
  - Else on a tick: `projectile_v` -= `STEP`. `projectile_h` stays constant.
- COOLDOWN: an 8-bit counter counts ticks. Goes to READY after `COOLDOWN_TICKS` ticks.
- `stop`=1 has top priority in every state: park, clear `active` and the cooldown counter, go to INIT. `shots` is retained.
- Fire edges outside READY are dropped, not queued. A held `fire` yields exactly one shot; the button must be released and pressed again.
- `collision` outside FLIGHT is ignored.

## Timing
- `fire` rising at edge k (`fire_d`=0, state READY): new position, `active`, `shot_fired` and `shots` are all visible after edge k. `shot_fired` drops after edge k+1.
- The tick counter is free-running from reset over 0..`TICK_DIV-1`. A tick is the cycle where the count equals `TICK_DIV-1`. It is not realigned on fire, so the first step comes 1..`TICK_DIV` cycles after launch.
- `collision` in the same cycle as a tick: collision wins, no step is taken.
- Collision or top retirement is registered: parked position and `active`=0 are visible one edge later.
- `reset` mid-flight parks the projectile immediately (asynchronous).

## Configuration
- `PROJECTILE_COOLDOWN_EN` defined: COOLDOWN state and counter are present, as described above.
- Not defined: COOLDOWN and its counter are compiled out. Retirement goes straight to READY, and a fire edge on the very next edge is accepted. `COOLDOWN_TICKS` is unused.

## Structure
- Shared package `game_defs`: coordinate width (10), `SCREEN_W`=640, `SCREEN_H`=480, `PARK_H`/`PARK_V`=0, and the one-hot state localparams used by this block and the fleet.
- One sub-module, `move_tick_gen`, holds the parameterised `TICK_DIV` counter and emits the tick pulse.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `STEP`=5, `TOP_LIMIT`=10, `SPAWN_OFFSET`=20, `COOLDOWN_TICKS`=2.
- Reset, then `start`, then fire edge with ship (300,450) -> next cycle projectile at (300,430), `active`=1, one-cycle `shot_fired`, `shots`=1.
- Uninterrupted flight from v=430 -> reaches v=10 after 84 ticks, parks at (0,0) on the 85th, `active`=0.
- `collision` coincident with a tick at v=400 -> parks with no v=395. A fire edge one tick later is ignored (`shots` unchanged). A fire edge after 2 ticks launches.
- `fire` held high for 50 ticks -> exactly one shot. `stop` mid-flight -> parked, INIT, fire ignored until `start`.
- Ship (100,25) -> fire ignored, state stays READY.
- `PROJECTILE_COOLDOWN_EN` undefined: collision, then a fire edge on the following cycle -> launch accepted, `shots` increments.
